alu_cmd_sequencer: RTL and testbench

Command-issue stage directly upstream of the 8-bit combinational ALU (operands `in1`/`in2`, 4-bit `select`, 16-bit `out`). Buffers operand/opcode commands in a small FIFO and drives them into the ALU one at a time from registered outputs. Captures each ALU result into a holding register and presents it on a valid/ready result port. Intercepts divide/modulus by zero and reports an error instead of using the ALU result.

---
 rtl/alu_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Purpose: queues ALU commands, issues them from registered outputs, captures and returns results.
// Latency: command accepted at edge T (empty, idle) is popped at T+1 and its result is valid after T+3.
// Backpressure: res_ready low holds the result; the FIFO keeps accepting until full, then cmd_ready drops.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [3:0]         cmd_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [3:0]         alu_select,
  input  logic [2*WIDTH-1:0] alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic [3:0]         res_op,
  output logic               res_err,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_MOD = 4'b0101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

  logic [WIDTH-1:0]   mem_a_q  [DEPTH];
  logic [WIDTH-1:0]   mem_b_q  [DEPTH];
  logic [3:0]         mem_op_q [DEPTH];

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [WIDTH-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [3:0]         sel_q, sel_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]         res_op_q, res_op_d;
  logic               res_err_q, res_err_d;
  logic               res_valid_q, res_valid_d;

  logic push, pop, fifo_empty, div_zero;

  // cmd_ready comes only from the registered count, so a pop never frees a slot in the same cycle
  assign cmd_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign div_zero   = ((sel_q == OP_DIV) || (sel_q == OP_MOD)) && (in2_q == '0);

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_select = sel_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign res_err    = res_err_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // Next-state: FSM sequencing, FIFO pointer/count bookkeeping and output register loads
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    sel_d       = sel_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        res_err_d   = div_zero;
        res_data_d  = div_zero ? '1 : alu_out;
        res_op_d    = sel_q;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      in1_d    = mem_a_q[rd_ptr_q];
      in2_d    = mem_b_q[rd_ptr_q];
      sel_d    = mem_op_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care while the count says the slot is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= cmd_a;
      mem_b_q[wr_ptr_q]  <= cmd_b;
      mem_op_q[wr_ptr_q] <= cmd_op;
    end
  end

  // Control state and registered outputs; reset drops queued commands and any held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      sel_q       <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      sel_q       <= sel_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached to the alu_* port.
// Results are collected on each handshake and compared against hand-computed values.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  alu_in1, alu_in2;
  logic [3:0]  alu_select;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_op;
  logic        res_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] q_data[$];
  logic [3:0]  q_op[$];
  logic        q_err[$];
  int          q_cyc[$];

  alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; divide/modulus by zero returns a marker the DUT must override
  always_comb begin
    logic [15:0] a, b;
    a = {8'h00, alu_in1};
    b = {8'h00, alu_in2};
    case (alu_select)
      4'b0000: alu_out = a;
      4'b0001: alu_out = b;
      4'b0010: alu_out = a + b;
      4'b0011: alu_out = a - b;
      4'b0100: alu_out = (b == 16'd0) ? 16'h0BAD : a / b;
      4'b0101: alu_out = (b == 16'd0) ? 16'h0BAD : a % b;
      4'b1010: alu_out = a * b;
      4'b1111: alu_out = (a ^ b) >> 1;
      default: alu_out = {alu_in1, alu_in2};
    endcase
  end

  always @(posedge clk) cyc++;

  // Record every result that will be handshaken on the coming edge
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      q_data.push_back(res_data);
      q_op.push_back(res_op);
      q_err.push_back(res_err);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_op.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int  waited;
    bit  ok;
    waited    = 0;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_results(input int n, input string tag);
    int w;
    w = 0;
    while (q_data.size() < n && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_count"}, 32'(q_data.size()), 32'(n));
  endtask

  task automatic expect_res(input string tag, input logic [15:0] data,
                            input logic [3:0] op, input logic err);
    logic [15:0] gd;
    logic [3:0]  go;
    logic        ge;
    gd = 16'hDEAD;
    go = 4'hX;
    ge = 1'bX;
    if (q_data.size() > 0) begin
      gd = q_data.pop_front();
      go = q_op.pop_front();
      ge = q_err.pop_front();
      void'(q_cyc.pop_front());
    end
    check({tag, "_data"}, 32'(gd), 32'(data));
    check({tag, "_op"},   32'(go), 32'(op));
    check({tag, "_err"},  32'(ge), 32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_in1", 32'(alu_in1), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single command, exact latency
    cmd_valid = 1'b1; cmd_a = 8'd10; cmd_b = 8'd5; cmd_op = 4'b0010;
    tick();
    cmd_valid = 1'b0;
    check("t1_busy_after_push", 32'(busy), 32'd1);
    check("t1_valid_T", 32'(res_valid), 32'd0);
    tick();
    check("t1_alu_in1", 32'(alu_in1), 32'd10);
    check("t1_alu_in2", 32'(alu_in2), 32'd5);
    check("t1_alu_select", 32'(alu_select), 32'd2);
    tick();
    check("t1_valid_T2", 32'(res_valid), 32'd0);
    tick();
    check("t1_valid_T3", 32'(res_valid), 32'd1);
    check("t1_res_data", 32'(res_data), 32'd15);
    check("t1_res_op", 32'(res_op), 32'd2);
    check("t1_res_err", 32'(res_err), 32'd0);
    tick();
    check("t1_hold_valid", 32'(res_valid), 32'd1);
    check("t1_hold_data", 32'(res_data), 32'd15);
    res_ready = 1'b1;
    tick();
    check("t1_valid_after_hs", 32'(res_valid), 32'd0);
    check("t1_busy_after_hs", 32'(busy), 32'd0);
    clear_q();

    // Order and back-to-back throughput
    push_cmd(8'd10, 8'd5, 4'b1010);
    push_cmd(8'd10, 8'd5, 4'b0011);
    push_cmd(8'd10, 8'd5, 4'b1111);
    wait_results(3, "t2");
    if (q_cyc.size() >= 3) begin
      check("t2_spacing01", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
      check("t2_spacing12", 32'(q_cyc[2] - q_cyc[1]), 32'd3);
    end
    expect_res("t2_r0", 16'd50, 4'b1010, 1'b0);
    expect_res("t2_r1", 16'd5,  4'b0011, 1'b0);
    expect_res("t2_r2", 16'd7,  4'b1111, 1'b0);
    repeat (3) tick();
    clear_q();

    // Divide and modulus by zero
    push_cmd(8'd10, 8'd0, 4'b0100);
    push_cmd(8'd10, 8'd0, 4'b0101);
    push_cmd(8'd10, 8'd5, 4'b0100);
    wait_results(3, "t3");
    expect_res("t3_div0", 16'hFFFF, 4'b0100, 1'b1);
    expect_res("t3_mod0", 16'hFFFF, 4'b0101, 1'b1);
    expect_res("t3_div",  16'd2,    4'b0100, 1'b0);
    repeat (3) tick();
    clear_q();

    // Fill under backpressure: one in flight plus DEPTH queued, sixth must wait
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'd10, 8'd5, 4'(i));
    cmd_valid = 1'b1; cmd_a = 8'd10; cmd_b = 8'd5; cmd_op = 4'd5;
    repeat (3) tick();
    check("t4_cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("t4_res_valid_held", 32'(res_valid), 32'd1);
    check("t4_res_data_held", 32'(res_data), 32'd10);
    check("t4_no_results_yet", 32'(q_data.size()), 32'd0);
    res_ready = 1'b1;
    push_cmd(8'd10, 8'd5, 4'd5);
    wait_results(6, "t4");
    expect_res("t4_r0", 16'd10, 4'd0, 1'b0);
    expect_res("t4_r1", 16'd5,  4'd1, 1'b0);
    expect_res("t4_r2", 16'd15, 4'd2, 1'b0);
    expect_res("t4_r3", 16'd5,  4'd3, 1'b0);
    expect_res("t4_r4", 16'd2,  4'd4, 1'b0);
    expect_res("t4_r5", 16'd0,  4'd5, 1'b0);
    repeat (3) tick();
    clear_q();

    // Reset while holding a result with commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'd10, 8'd5, 4'b0010);
    begin
      int w;
      w = 0;
      while (!res_valid && w < 20) begin
        tick();
        w++;
      end
    end
    check("t5_valid_before_rst", 32'(res_valid), 32'd1);
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t5_res_valid", 32'(res_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_alu_in1", 32'(alu_in1), 32'd0);
    check("t5_alu_in2", 32'(alu_in2), 32'd0);
    check("t5_alu_select", 32'(alu_select), 32'd0);
    check("t5_res_data", 32'(res_data), 32'd0);
    check("t5_res_op", 32'(res_op), 32'd0);
    check("t5_res_err", 32'(res_err), 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (20) tick();
    check("t5_no_stale_result", 32'(q_data.size()), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
